// File: rtl/nibble_stream_assembler.sv
// rtl/nibble_stream_assembler.sv - assembles a valid/ready nibble stream into bytes queued in a small output FIFO
module nibble_stream_assembler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     swap_en,
    input  logic [3:0]               nib_in,
    input  logic                     nib_valid,
    output logic                     nib_ready,
    input  logic                     flush,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     partial,
    output logic [CNT_W-1:0]         byte_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        HALF
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        held_q;
    logic              swap_q;
    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              push;
    logic              pop;
    logic              first_accept;
    logic [7:0]        assembled;

    // nib_ready depends only on state, fill level, flush and reset - never on nib_valid
    always_comb begin
        state_d      = state_q;
        nib_ready    = 1'b0;
        push         = 1'b0;
        first_accept = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    nib_ready = !flush;
                    if (nib_valid && !flush) begin
                        first_accept = 1'b1;
                        state_d      = HALF;
                    end
                end
                HALF: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        nib_ready = (count_q != FULL_CNT);
                        if (nib_valid && (count_q != FULL_CNT)) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Order follows the swap setting captured with the first nibble, not the live input
    assign assembled = swap_q ? {nib_in, held_q} : {held_q, nib_in};
    assign pop       = (count_q != '0) && byte_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            held_q  <= 4'h0;
            swap_q  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            if (first_accept) begin
                held_q <= nib_in;
                swap_q <= swap_en;
            end
            if (push) begin
                mem[wr_ptr] <= assembled;
                wr_ptr      <= wr_ptr + AW'(1);
                cnt_q       <= cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign byte_out   = mem[rd_ptr];
    assign byte_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign partial    = (state_q == HALF);
    assign byte_cnt   = cnt_q;

endmodule
